mux_masters: RTL and testbench
==============================

Name: mux_masters

Overview:
- Slave-side counterpart of the crossbar's master-side address demux.
- Arbitrates two master ports onto one slave port using the same req/addr/cmd/wdata → ack/rdata protocol.
- Grants are round-robin and locked for the whole transaction.
- Request fields are registered at grant; the slave ack and rdata are returned only to the granted master.

Parameters:
- N, 32, data and address width.
- TIMEOUT, 16, slave-ack timeout in cycles (used only with MUX_MASTERS_TIMEOUT_EN).
- ERR_DATA, 32'hDEADBEEF, rdata returned on a timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- master_1_req  in  1  master 1 request; held until master_1_ack.
- master_1_addr  in  N  master 1 address.
- master_1_cmd  in  1  master 1 command: 0 = read, 1 = write.
- master_1_wdata  in  N  master 1 write data.
- master_1_ack  out  1  master 1 completion pulse.
- master_1_rdata  out  N  master 1 read data, valid with ack.
- master_2_req / master_2_addr / master_2_cmd / master_2_wdata / master_2_ack / master_2_rdata: same as master 1.
- slave_req  out  1  request to slave.
- slave_addr  out  N  latched address.
- slave_cmd  out  1  latched command.
- slave_wdata  out  N  latched write data.
- slave_ack  in  1  slave completion pulse.
- slave_rdata  in  N  slave read data, valid with slave_ack.
- grant  out  1  owner of the current transaction: 0 = master 1, 1 = master 2.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE, rr_ptr = 0 (master 1 preferred).
  - slave_req = 0; slave_addr / slave_cmd / slave_wdata = 0; grant = 0.
  - master_x_ack = 0; master_x_rdata = 0.
  - Reset mid-transaction aborts it: no ack is issued to any master, and a later slave_ack is ignored.
- IDLE:
  - Only master_1_req → grant = 0.
  - Only master_2_req → grant = 1.
  - Both → grant = rr_ptr.
  - On a grant: latch that master's addr/cmd/wdata into slave_*, set slave_req = 1, go to BUSY.
  - Net latency: req sampled at edge t gives slave_req = 1 from t+1.
- BUSY:
  - slave_req stays 1 and slave_* stay stable; changes on master inputs are ignored.
  - On slave_ack = 1, in the same cycle (combinational): master_{grant}_ack = 1 and master_{grant}_rdata = slave_rdata.
  - The other master's ack and rdata stay 0.
  - At the next edge: slave_req = 0, rr_ptr = ~grant, state = IDLE.
- A master still asserting req in the IDLE cycle after its ack is treated as a new request.
  - With both masters requesting, the round-robin pointer guarantees alternation: M1, M2, M1, ...
- slave_ack while IDLE is ignored: no master ack.
- Ungranted master outputs are always 0. rdata is 0 whenever ack is 0.
- Throughput: one transaction per (slave ack latency + 2) cycles.
- Width rules: addr, wdata and rdata pass through unmodified at N bits; there is no address decode.

Optional Feature:
- Macro: MUX_MASTERS_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT)-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If slave_ack has not arrived when the counter equals TIMEOUT-1: master_{grant}_ack = 1 with rdata = ERR_DATA that cycle, then IDLE and slave_req = 0.
  - slave_ack in the same cycle as the timeout wins: real rdata is returned.
  - A late slave_ack after a timeout falls in IDLE and is ignored.
- Undefined: no counter; BUSY waits indefinitely for slave_ack.

Decomposition:
- Package crossbar_pkg holds:
  - N_DEF = 32.
  - CMD_READ = 1'b0, CMD_WRITE = 1'b1.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - ERR_DATA_DEF.
- Sub-module rr_arb2: inputs req[1:0] and rr_ptr; output grant index and any_req. Combinational, reused by other slave ports.

Test Plan:
- Reset: rst = 0 for 4 cycles with both reqs high → slave_req = 0, all acks = 0, grant = 0; after release, first grant goes to master 1.
- Single read: master_2 req, addr = 32'h8000_0004, cmd = 0; slave acks 3 cycles later with rdata = 32'hA5A5_A5A5 → master_2_ack pulses once with that rdata; master_1_ack = 0 and master_1_rdata = 0 throughout.
- Contention: both masters hold req for 4 transactions, slave acks 1 cycle after slave_req → grant sequence 0, 1, 0, 1; slave_wdata matches the owner's wdata latched at grant.
- Stability: master_1 changes wdata from 32'h1 to 32'h2 during BUSY → slave_wdata stays 32'h1 until ack.
- Stray ack and mid-transaction reset: slave_ack while IDLE gives no master ack; rst low during BUSY gives slave_req = 0 next cycle and no master ack.
- With MUX_MASTERS_TIMEOUT_EN and TIMEOUT = 16:
  - Slave never acks → master ack at BUSY cycle 16 with rdata 32'hDEADBEEF.
  - slave_ack coincident with the timeout cycle → real rdata is returned.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared crossbar types and defaults: widths, command encoding, arbiter states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package crossbar_pkg;

    localparam int N_DEF       = 32;
    localparam int TIMEOUT_DEF = 16;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [N_DEF-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index of the other port of a two-way arbiter.
    function automatic logic rr_other(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/mux_masters_rr_arb2.sv
// Two-way round-robin pick: lone requester wins, ties go to rr_ptr.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       grant,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        grant   = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_ptr;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_masters.sv
// Two masters onto one slave port, round-robin grant held for the whole transaction.
// Latency: req at edge t -> slave_req from t+1; slave_ack returned to the owner combinationally.
// Backpressure: masters hold req until their ack; optional MUX_MASTERS_TIMEOUT_EN bounds the wait.
module mux_masters
    import crossbar_pkg::*;
#(
    parameter int            N        = N_DEF,
    parameter int            TIMEOUT  = TIMEOUT_DEF,
    parameter logic [N-1:0]  ERR_DATA = N'(ERR_DATA_DEF)
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         master_1_req,
    input  logic [N-1:0] master_1_addr,
    input  logic         master_1_cmd,
    input  logic [N-1:0] master_1_wdata,
    output logic         master_1_ack,
    output logic [N-1:0] master_1_rdata,

    input  logic         master_2_req,
    input  logic [N-1:0] master_2_addr,
    input  logic         master_2_cmd,
    input  logic [N-1:0] master_2_wdata,
    output logic         master_2_ack,
    output logic [N-1:0] master_2_rdata,

    output logic         slave_req,
    output logic [N-1:0] slave_addr,
    output logic         slave_cmd,
    output logic [N-1:0] slave_wdata,
    input  logic         slave_ack,
    input  logic [N-1:0] slave_rdata,

    output logic         grant
);

    typedef struct packed {
        logic [N-1:0] addr;
        logic         cmd;
        logic [N-1:0] wdata;
    } xfer_t;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mux_masters: TIMEOUT must be at least 1");
    end

    arb_state_t state_q, state_d;
    logic       rr_ptr_q;
    logic       grant_q;
    logic       slave_req_q;
    xfer_t      xfer_q;
    xfer_t      pick;
    logic       arb_grant;
    logic       arb_any;
    logic       timeout_hit;
    logic       done;
    logic [N-1:0] ret_data;

    rr_arb2 u_arb (
        .req     ({master_2_req, master_1_req}),
        .rr_ptr  (rr_ptr_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

`ifdef MUX_MASTERS_TIMEOUT_EN
    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] to_cnt_q;

    // Held at zero while idle, so the first BUSY cycle always sees 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
        end
    end

    assign timeout_hit = (state_q == BUSY) && (to_cnt_q == LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign done     = slave_ack | timeout_hit;
    assign ret_data = slave_ack ? slave_rdata : ERR_DATA;

    always_comb begin
        pick = '0;
        if (arb_grant) begin
            pick.addr  = master_2_addr;
            pick.cmd   = master_2_cmd;
            pick.wdata = master_2_wdata;
        end else begin
            pick.addr  = master_1_addr;
            pick.cmd   = master_1_cmd;
            pick.wdata = master_1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        master_1_ack   = 1'b0;
        master_1_rdata = '0;
        master_2_ack   = 1'b0;
        master_2_rdata = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    if (grant_q) begin
                        master_2_ack   = 1'b1;
                        master_2_rdata = ret_data;
                    end else begin
                        master_1_ack   = 1'b1;
                        master_1_rdata = ret_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at grant; master inputs are ignored while BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= 1'b0;
            grant_q     <= 1'b0;
            slave_req_q <= 1'b0;
            xfer_q      <= '0;
        end else if (state_q == IDLE) begin
            if (arb_any) begin
                grant_q     <= arb_grant;
                xfer_q      <= pick;
                slave_req_q <= 1'b1;
            end
        end else if (done) begin
            slave_req_q <= 1'b0;
            rr_ptr_q    <= rr_other(grant_q);
        end
    end

    assign slave_req   = slave_req_q;
    assign slave_addr  = xfer_q.addr;
    assign slave_cmd   = xfer_q.cmd;
    assign slave_wdata = xfer_q.wdata;
    assign grant       = grant_q;

endmodule

// File: tb/tb_mux_masters.sv
// Bench for mux_masters: reset/grant/stability vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mux_masters;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;
`ifdef MUX_MASTERS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m1_req = 1'b0, m1_cmd = 1'b0, m2_req = 1'b0, m2_cmd = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m2_addr = '0, m2_wdata = '0;
    logic        m1_ack, m2_ack;
    logic [31:0] m1_rdata, m2_rdata;
    logic        slave_req, slave_cmd, grant;
    logic [31:0] slave_addr, slave_wdata;
    logic        slave_ack = 1'b0;
    logic [31:0] slave_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_masters dut (
        .clk            (clk),
        .rst            (rst),
        .master_1_req   (m1_req),
        .master_1_addr  (m1_addr),
        .master_1_cmd   (m1_cmd),
        .master_1_wdata (m1_wdata),
        .master_1_ack   (m1_ack),
        .master_1_rdata (m1_rdata),
        .master_2_req   (m2_req),
        .master_2_addr  (m2_addr),
        .master_2_cmd   (m2_cmd),
        .master_2_wdata (m2_wdata),
        .master_2_ack   (m2_ack),
        .master_2_rdata (m2_rdata),
        .slave_req      (slave_req),
        .slave_addr     (slave_addr),
        .slave_cmd      (slave_cmd),
        .slave_wdata    (slave_wdata),
        .slave_ack      (slave_ack),
        .slave_rdata    (slave_rdata),
        .grant          (grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One row = inputs for one cycle + outputs expected at that cycle's negedge.
    typedef struct {
        logic        rst, r1, r2;
        logic [31:0] w1, w2;
        logic        sack;
        logic [31:0] srd;
        logic        e_req, e_grant;
        logic [31:0] e_wd;
        logic        e_a1, e_a2;
        logic [31:0] e_rd1, e_rd2;
    } vec_t;

    vec_t tbl[17];

    task automatic run_timeout(input bit coincide, input logic [31:0] exp_rd);
        int busy_n = 0;
        int ack_at = 0;
        int acks   = 0;
        tick();
        m1_req = 1'b1; m1_addr = 32'h40; m1_cmd = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (slave_req) busy_n++;
            check("to_m2_ack", m2_ack, 1'b0);
            if (m1_ack) begin
                acks++;
                if (ack_at == 0) ack_at = busy_n;
                check("to_rdata", m1_rdata, exp_rd);
            end
            tick();
            slave_ack   = coincide && (busy_n == TIMEOUT - 1);
            slave_rdata = slave_ack ? 32'h1234_5678 : 32'h0;
            if (acks != 0) m1_req = 1'b0;
            if (acks != 0 && c > TIMEOUT + 4) break;
        end
        check("to_ack_cycle", ack_at, TIMEOUT);
        check("to_ack_count", acks, 1);
    endtask

    initial begin
        bit          mb, mo, pref;
        int          mcnt;
        logic [31:0] la, lw;
        logic        lc, done, e1, e2;
        logic [31:0] e_rd;
        int          busy_n, acks, gi;
        logic        prev_req, sack_next;
        logic [31:0] pw1, pw2;
        logic [31:0] exp_wd;
        logic        exp_g;

        //           rst r1 r2 w1     w2      sack srd     | req g  wd      a1 a2 rd1     rd2
        tbl[0]  = '{1'b0,1'b1,1'b1,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[1]  = '{1'b0,1'b1,1'b1,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[2]  = '{1'b0,1'b1,1'b1,32'h1,32'h22,1'b1,32'h9,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[3]  = '{1'b0,1'b1,1'b1,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[4]  = '{1'b1,1'b1,1'b1,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[5]  = '{1'b1,1'b1,1'b1,32'h1,32'h22,1'b1,32'h55, 1'b1,1'b0,32'h1, 1'b1,1'b0,32'h55,32'h0};
        tbl[6]  = '{1'b1,1'b1,1'b1,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h1, 1'b0,1'b0,32'h0, 32'h0};
        tbl[7]  = '{1'b1,1'b1,1'b1,32'h1,32'h22,1'b1,32'h66, 1'b1,1'b1,32'h22,1'b0,1'b1,32'h0, 32'h66};
        tbl[8]  = '{1'b1,1'b1,1'b0,32'h1,32'h22,1'b0,32'h0,  1'b0,1'b1,32'h22,1'b0,1'b0,32'h0, 32'h0};
        tbl[9]  = '{1'b1,1'b1,1'b0,32'h2,32'h22,1'b0,32'h0,  1'b1,1'b0,32'h1, 1'b0,1'b0,32'h0, 32'h0};
        tbl[10] = '{1'b1,1'b1,1'b0,32'h2,32'h22,1'b0,32'h0,  1'b1,1'b0,32'h1, 1'b0,1'b0,32'h0, 32'h0};
        tbl[11] = '{1'b1,1'b1,1'b0,32'h2,32'h22,1'b1,32'h77, 1'b1,1'b0,32'h1, 1'b1,1'b0,32'h77,32'h0};
        tbl[12] = '{1'b1,1'b0,1'b0,32'h2,32'h22,1'b1,32'h88, 1'b0,1'b0,32'h1, 1'b0,1'b0,32'h0, 32'h0};
        tbl[13] = '{1'b1,1'b0,1'b1,32'h2,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h1, 1'b0,1'b0,32'h0, 32'h0};
        tbl[14] = '{1'b0,1'b0,1'b1,32'h2,32'h22,1'b0,32'h0,  1'b1,1'b1,32'h22,1'b0,1'b0,32'h0, 32'h0};
        tbl[15] = '{1'b1,1'b0,1'b0,32'h2,32'h22,1'b1,32'h99, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};
        tbl[16] = '{1'b1,1'b0,1'b0,32'h2,32'h22,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 32'h0};

        m1_addr = 32'h100; m1_cmd = 1'b1; m2_addr = 32'h200; m2_cmd = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            rst = tbl[i].rst; m1_req = tbl[i].r1; m2_req = tbl[i].r2;
            m1_wdata = tbl[i].w1; m2_wdata = tbl[i].w2;
            slave_ack = tbl[i].sack; slave_rdata = tbl[i].srd;
            @(negedge clk);
            check($sformatf("vec%0d_slave_req", i), slave_req, tbl[i].e_req);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].e_grant);
            check($sformatf("vec%0d_slave_wdata", i), slave_wdata, tbl[i].e_wd);
            check($sformatf("vec%0d_m1_ack", i), m1_ack, tbl[i].e_a1);
            check($sformatf("vec%0d_m2_ack", i), m2_ack, tbl[i].e_a2);
            check($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].e_rd1);
            check($sformatf("vec%0d_m2_rdata", i), m2_rdata, tbl[i].e_rd2);
        end

        // Single read from master 2, slave answers 3 cycles after slave_req rises.
        tick();
        slave_ack = 1'b0; slave_rdata = '0;
        m2_req = 1'b1; m2_addr = 32'h8000_0004; m2_cmd = 1'b0; m2_wdata = 32'h77;
        busy_n = 0; acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (slave_req) busy_n++;
            check("rd_m1_ack", m1_ack, 1'b0);
            check("rd_m1_rdata", m1_rdata, 32'h0);
            if (slave_req && busy_n == 1) begin
                check("rd_addr", slave_addr, 32'h8000_0004);
                check("rd_cmd", slave_cmd, 1'b0);
                check("rd_grant", grant, 1'b1);
            end
            if (m2_ack) begin
                acks++;
                check("rd_m2_rdata", m2_rdata, 32'hA5A5_A5A5);
                check("rd_ack_cycle", busy_n, 4);
            end else begin
                check("rd_m2_rdata_idle", m2_rdata, 32'h0);
            end
            tick();
            slave_ack   = (busy_n == 3);
            slave_rdata = slave_ack ? 32'hA5A5_A5A5 : 32'h0;
            if (acks != 0) m2_req = 1'b0;
        end
        check("rd_ack_count", acks, 1);

        // Contention: both hold req, slave acks one cycle after slave_req rises.
        tick();
        m1_req = 1'b1; m2_req = 1'b1;
        m1_wdata = $urandom; m2_wdata = $urandom;
        gi = 0; acks = 0; prev_req = 1'b0; pw1 = '0; pw2 = '0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(negedge clk);
            if (slave_req && !prev_req) begin
                exp_g  = gi[0];
                exp_wd = exp_g ? pw2 : pw1;
                check($sformatf("cont_grant%0d", gi), grant, exp_g);
                check($sformatf("cont_wdata%0d", gi), slave_wdata, exp_wd);
                gi++;
            end
            if (m1_ack || m2_ack) acks++;
            sack_next = slave_req && !prev_req;
            prev_req  = slave_req;
            tick();
            pw1 = m1_wdata; pw2 = m2_wdata;
            m1_wdata = $urandom; m2_wdata = $urandom;
            slave_ack = sack_next;
        end
        check("cont_transactions", acks, 4);
        m1_req = 1'b0; m2_req = 1'b0; slave_ack = 1'b0;

        if (TO_EN) begin
            run_timeout(1'b0, ERR);
            // Late slave ack after the timeout lands in IDLE.
            tick();
            slave_ack = 1'b1; slave_rdata = 32'h5;
            @(negedge clk);
            check("late_ack_m1", m1_ack, 1'b0);
            check("late_ack_m2", m2_ack, 1'b0);
            tick();
            slave_ack = 1'b0;
            run_timeout(1'b1, 32'h1234_5678);
        end

        // Random traffic against the reference model.
        tick();
        rst = 1'b0; m1_req = 1'b0; m2_req = 1'b0; slave_ack = 1'b0;
        tick();
        rst = 1'b1;
        mb = 1'b0; mo = 1'b0; pref = 1'b0; mcnt = 0; la = '0; lw = '0; lc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            done = mb && (slave_ack || (TO_EN && mcnt == TIMEOUT));
            e1   = done && !mo;
            e2   = done && mo;
            e_rd = slave_ack ? slave_rdata : ERR;
            check("rnd_slave_req", slave_req, mb);
            check("rnd_slave_addr", slave_addr, la);
            check("rnd_slave_cmd", slave_cmd, lc);
            check("rnd_slave_wdata", slave_wdata, lw);
            check("rnd_grant", grant, mo);
            check("rnd_m1_ack", m1_ack, e1);
            check("rnd_m2_ack", m2_ack, e2);
            check("rnd_m1_rdata", m1_rdata, e1 ? e_rd : 32'h0);
            check("rnd_m2_rdata", m2_rdata, e2 ? e_rd : 32'h0);

            if (!rst) begin
                mb = 1'b0; mo = 1'b0; pref = 1'b0; la = '0; lw = '0; lc = 1'b0;
            end else if (!mb) begin
                if (m1_req || m2_req) begin
                    mo   = (m1_req && m2_req) ? pref : m2_req;
                    la   = mo ? m2_addr : m1_addr;
                    lc   = mo ? m2_cmd : m1_cmd;
                    lw   = mo ? m2_wdata : m1_wdata;
                    mb   = 1'b1;
                    mcnt = 1;
                end
            end else if (done) begin
                mb   = 1'b0;
                pref = !mo;
            end else begin
                mcnt++;
            end

            tick();
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if (!m1_req || e1) m1_req = ($urandom_range(0, 2) != 0);
            if (!m2_req || e2) m2_req = ($urandom_range(0, 2) != 0);
            m1_addr = $urandom; m1_wdata = $urandom; m1_cmd = $urandom_range(0, 1);
            m2_addr = $urandom; m2_wdata = $urandom; m2_cmd = $urandom_range(0, 1);
            slave_ack   = mb ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 10);
            slave_rdata = $urandom;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
